// File: rtl/z_result_reg.sv
// Z result register: captures the ALU/shifter {high, low} result pair and serves either half to the bus.
// Optional macro Z_BYPASS_EN forwards the incoming capture data to the bus when a read coincides.
module z_result_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] z_low_in,
  input  logic [WIDTH-1:0] z_high_in,
  input  logic             z_in,
  input  logic             z_low_out,
  input  logic             z_high_out,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_drive,
  output logic [WIDTH-1:0] z_low_q,
  output logic [WIDTH-1:0] z_high_q,
  output logic             result_valid,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             overrun,
  output logic             conflict
);

  typedef enum logic [1:0] {StEmpty, StFull, StLowLeft, StHighLeft} state_e;

  state_e state_q, state_d, read_state;

  logic rd_low, rd_high, rd_both;
  logic overrun_set;
  logic [WIDTH-1:0] low_src, high_src;

  assign rd_low  = z_low_out & ~z_high_out;
  assign rd_high = z_high_out & ~z_low_out;
  assign rd_both = z_low_out & z_high_out;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // State reached by this cycle's read alone; capture overrides it below.
    read_state = state_q;
    case (state_q)
      StFull: begin
        if (rd_low) begin
          read_state = StHighLeft;
        end else if (rd_high) begin
          read_state = StLowLeft;
        end
      end
      StHighLeft: if (rd_high) read_state = StEmpty;
      StLowLeft:  if (rd_low)  read_state = StEmpty;
      default: ;
    endcase

    state_d = read_state;
    if (z_in) begin
`ifdef Z_BYPASS_EN
      // The forwarded half has already been consumed by the reader.
      if (rd_low) begin
        state_d = StHighLeft;
      end else if (rd_high) begin
        state_d = StLowLeft;
      end else begin
        state_d = StFull;
      end
`else
      state_d = StFull;
`endif
    end
  end

  // Overwrite loses data only if something stays unread after this cycle's read.
  assign overrun_set = z_in & (read_state != StEmpty);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      z_low_q   <= '0;
      z_high_q  <= '0;
      zero_flag <= 1'b1;
      neg_flag  <= 1'b0;
      overrun   <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      if (z_in) begin
        z_low_q   <= z_low_in;
        z_high_q  <= z_high_in;
        zero_flag <= ({z_high_in, z_low_in} == '0);
        neg_flag  <= z_low_in[WIDTH-1];
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
      if (rd_both) begin
        conflict <= 1'b1;
      end else if (ovr_clr) begin
        conflict <= 1'b0;
      end
    end
  end

`ifdef Z_BYPASS_EN
  assign low_src  = z_in ? z_low_in  : z_low_q;
  assign high_src = z_in ? z_high_in : z_high_q;
`else
  assign low_src  = z_low_q;
  assign high_src = z_high_q;
`endif

  always_comb begin
    bus_out   = '0;
    bus_drive = 1'b0;
    if (rd_low) begin
      bus_out   = low_src;
      bus_drive = 1'b1;
    end else if (rd_high) begin
      bus_out   = high_src;
      bus_drive = 1'b1;
    end
  end

  assign result_valid = (state_q != StEmpty);

endmodule

// File: tb/tb_z_result_reg.sv
// Directed bench for z_result_reg: capture, read sequencing, overrun/conflict flags, async reset.
module tb_z_result_reg;

`ifdef Z_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] z_low_in, z_high_in;
  logic        z_in, z_low_out, z_high_out, ovr_clr;
  logic [31:0] bus_out, z_low_q, z_high_q;
  logic        bus_drive, result_valid, zero_flag, neg_flag, overrun, conflict;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  z_result_reg #(.WIDTH(32)) dut (
    .clk          (clk),
    .clr          (clr),
    .z_low_in     (z_low_in),
    .z_high_in    (z_high_in),
    .z_in         (z_in),
    .z_low_out    (z_low_out),
    .z_high_out   (z_high_out),
    .ovr_clr      (ovr_clr),
    .bus_out      (bus_out),
    .bus_drive    (bus_drive),
    .z_low_q      (z_low_q),
    .z_high_q     (z_high_q),
    .result_valid (result_valid),
    .zero_flag    (zero_flag),
    .neg_flag     (neg_flag),
    .overrun      (overrun),
    .conflict     (conflict)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the extra #1 lets combinational outputs settle.
  task automatic set_in(input logic zi, input logic [31:0] lo, input logic [31:0] hi,
                        input logic ro_l, input logic ro_h, input logic oc);
    z_in       = zi;
    z_low_in   = lo;
    z_high_in  = hi;
    z_low_out  = ro_l;
    z_high_out = ro_h;
    ovr_clr    = oc;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_zlo"},  z_low_q,      32'h0);
    check({tag, "_zhi"},  z_high_q,     32'h0);
    check({tag, "_zero"}, zero_flag,    32'h1);
    check({tag, "_neg"},  neg_flag,     32'h0);
    check({tag, "_ovr"},  overrun,      32'h0);
    check({tag, "_cnf"},  conflict,     32'h0);
    check({tag, "_rv"},   result_valid, 32'h0);
    check({tag, "_drv"},  bus_drive,    32'h0);
    check({tag, "_bus"},  bus_out,      32'h0);
  endtask

  initial begin
    clr = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_reset_state("rst");
    clr = 1'b1;
    tick;

    // 0x00015555 SHL 7: low 0x00AAAA80, high 0; read low then high
    set_in(1'b1, 32'h00AAAA80, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("shl_zlo", z_low_q, 32'h00AAAA80);
    check("shl_zhi", z_high_q, 32'h0);
    check("shl_zero", zero_flag, 32'h0);
    check("shl_neg", neg_flag, 32'h0);
    check("shl_rv_full", result_valid, 32'h1);
    check("shl_bus_lo", bus_out, 32'h00AAAA80);
    check("shl_drv_lo", bus_drive, 32'h1);
    tick;
    check("shl_rv_hleft", result_valid, 32'h1);
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("shl_bus_hi", bus_out, 32'h0);
    check("shl_drv_hi", bus_drive, 32'h1);
    tick;
    check("shl_rv_empty", result_valid, 32'h0);
    check("shl_ovr", overrun, 32'h0);

    // Stale read while empty
    set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("stale_bus", bus_out, 32'h00AAAA80);
    check("stale_drv", bus_drive, 32'h1);
    tick;
    check("stale_rv", result_valid, 32'h0);
    check("stale_ovr", overrun, 32'h0);

    // 0xAAA00000 SHL 7: high 0x55, low 0x50000000; read high -> LOW_LEFT
    set_in(1'b1, 32'h50000000, 32'h00000055, 1'b0, 1'b0, 1'b0);
    tick;
    check("shr2_zlo", z_low_q, 32'h50000000);
    check("shr2_zhi", z_high_q, 32'h00000055);
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("shr2_bus_hi", bus_out, 32'h00000055);
    tick;
    check("shr2_rv", result_valid, 32'h1);
    // Capture + reading the only unread half: no overrun
    set_in(1'b1, 32'h50000000, 32'h00000055, 1'b1, 1'b0, 1'b0);
    check("cap_rd_bus", bus_out, 32'h50000000);
    tick;
    check("cap_rd_ovr", overrun, 32'h0);
    set_in(1'b1, 32'h50000000, 32'h00000055, 1'b0, 1'b0, 1'b0);
    tick;
    check("ovr_set", overrun, 32'h1);
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick;
    check("ovr_clr", overrun, 32'h0);
    // Set beats clear in the same cycle
    set_in(1'b1, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b1);
    tick;
    check("ovr_setwins", overrun, 32'h1);
    check("neg_set", neg_flag, 32'h1);
    check("neg_zero", zero_flag, 32'h0);
    set_in(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick;
    check("zero_set", zero_flag, 32'h1);
    check("zero_neg", neg_flag, 32'h0);
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick;
    check("ovr_clr2", overrun, 32'h0);
    // Drain FULL -> HIGH_LEFT -> EMPTY
    set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick;
    check("drain_rv1", result_valid, 32'h1);
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick;
    check("drain_rv0", result_valid, 32'h0);

    // Stored low 0x1234, capture 0x5678 with a low read in the same cycle
    set_in(1'b1, 32'h00001234, 32'h0000ABCD, 1'b0, 1'b0, 1'b0);
    tick;
    check("pre_ovr", overrun, 32'h0);
    set_in(1'b1, 32'h00005678, 32'h00009999, 1'b1, 1'b0, 1'b0);
    check("fwd_bus", bus_out, Bypass ? 32'h00005678 : 32'h00001234);
    check("fwd_drv", bus_drive, 32'h1);
    tick;
    check("fwd_zlo", z_low_q, 32'h00005678);
    check("fwd_ovr", overrun, 32'h1);
    // FULL + high read -> LOW_LEFT; HIGH_LEFT + high read -> EMPTY
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("fwd_bus_hi", bus_out, 32'h00009999);
    tick;
    check("fwd_rv", result_valid, Bypass ? 32'h0 : 32'h1);
    check("fwd_ovrclr", overrun, 32'h0);

    // Conflicting requests: no drive, sticky conflict, state held
    set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("cnf_drv", bus_drive, 32'h0);
    check("cnf_bus", bus_out, 32'h0);
    tick;
    check("cnf_flag", conflict, 32'h1);
    check("cnf_rv", result_valid, Bypass ? 32'h0 : 32'h1);
    set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    tick;
    check("cnf_clr", conflict, 32'h0);
    check("cnf_rv_after", result_valid, 32'h0);

    // Capture from EMPTY with a read: never an overrun
    set_in(1'b1, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0, 1'b0);
    tick;
    check("empty_cap_ovr", overrun, 32'h0);
    check("empty_cap_rv", result_valid, 32'h1);

    // Async reset while FULL, before the next clock edge
    set_in(1'b1, 32'hCAFEF00D, 32'h0BADBEEF, 1'b0, 1'b0, 1'b0);
    tick;
    set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("arst_pre_rv", result_valid, 32'h1);
    z_low_out = 1'b0;
    #1;
    clr = 1'b0;
    #1;
    check_reset_state("arst");
    tick;
    clr = 1'b1;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/z_result_reg.md
Name: z_result_reg

Overview:
- Downstream stage of the ALU/shifter datapath: captures the 64-bit result pair (z_high, z_low) produced by SHL_32 and the other ALU units into the Z register.
- Drives either half onto the 32-bit internal bus on request.
- Tracks per-half "unread" state, raises a sticky overrun when an unread result is overwritten, and latches zero/negative flags.

Parameters:
- WIDTH, 32, width of each result half and of the bus.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- clr  input  1  asynchronous, active-low reset.
- z_low_in  input  WIDTH  low half from ALU/shifter.
- z_high_in  input  WIDTH  high half from ALU/shifter.
- z_in  input  1  capture strobe; loads both halves at posedge.
- z_low_out  input  1  request to drive stored low half onto bus this cycle.
- z_high_out  input  1  request to drive stored high half onto bus this cycle.
- ovr_clr  input  1  synchronous clear of sticky overrun/conflict flags.
- bus_out  output  WIDTH  data driven toward the bus multiplexer.
- bus_drive  output  1  bus_out carries valid data this cycle.
- z_low_q  output  WIDTH  stored low half (debug/observe).
- z_high_q  output  WIDTH  stored high half.
- result_valid  output  1  at least one half is unread.
- zero_flag  output  1  last captured {high,low} == 0.
- neg_flag  output  1  bit WIDTH-1 of last captured low half.
- overrun  output  1  sticky: capture occurred while a half was unread.
- conflict  output  1  sticky: both out requests asserted in the same cycle.

Behaviour:
- Reset (clr=0, asynchronous):
  - z_low_q, z_high_q = 0.
  - zero_flag = 1; neg_flag, overrun, conflict = 0.
  - State = EMPTY, so result_valid = 0.
- States:
  - EMPTY: nothing unread.
  - FULL: both halves unread.
  - LOW_LEFT: high already read.
  - HIGH_LEFT: low already read.
- Capture (z_in=1 at posedge):
  - z_low_q <= z_low_in, z_high_q <= z_high_in.
  - zero_flag and neg_flag update.
  - Next state = FULL from any state; values visible one cycle after the strobe.
  - If the state was not EMPTY and the current-cycle read does not empty it, overrun <= 1.
- Read, combinational from stored registers (zero latency):
  - z_low_out only: bus_out = z_low_q, bus_drive = 1.
  - z_high_out only: bus_out = z_high_q, bus_drive = 1.
  - Both asserted: bus_out = 0, bus_drive = 0, conflict <= 1 at posedge, state unchanged.
  - Neither asserted: bus_out = 0, bus_drive = 0.
- Read state transitions at posedge:
  - FULL + low read -> HIGH_LEFT; FULL + high read -> LOW_LEFT.
  - HIGH_LEFT + high read -> EMPTY; LOW_LEFT + low read -> EMPTY.
  - Re-reading an already-read half is allowed: returns data, state unchanged.
  - Reading in EMPTY returns the stored (stale) value with bus_drive = 1 and no error.
- Simultaneous capture + read:
  - Bus returns the OLD stored value.
  - New value loaded; state = FULL.
  - Overrun is set only if another half remained unread besides the one being read.
- Sticky flags:
  - ovr_clr=1 clears overrun and conflict at posedge.
  - If a set condition occurs in the same cycle as ovr_clr, set wins.
- Reset mid-operation: immediate return to reset values regardless of clk.

Optional Feature:
- Macro: Z_BYPASS_EN.
- Defined:
  - When z_in and an out request coincide, bus_out carries the incoming z_low_in / z_high_in instead of the stored value (write-through forwarding).
  - State/overrun logic is unchanged, except the forwarded half is counted as read: capture + low read -> HIGH_LEFT.
- Undefined: old-value-on-bus behaviour exactly as in Behaviour.

Test Plan:
- Reset, then idle -> all outputs per reset list; zero_flag = 1, result_valid = 0, bus_drive = 0.
- Capture 0x00015555 SHL 7 (low = 0x00AAAA80, high = 0), read low then high on two cycles -> bus 0x00AAAA80 then 0x00000000; states FULL -> HIGH_LEFT -> EMPTY; zero_flag = 0, neg_flag = 0.
- Capture 0xAAA00000 SHL 7 (high = 0x00000055, low = 0x50000000), read high only, capture again -> overrun = 1; ovr_clr -> overrun = 0.
- Stored low = 0x1234, capture 0x5678 with z_low_out in the same cycle:
  - Without Z_BYPASS_EN: bus = 0x1234, state FULL, overrun = 1 if high was unread.
  - With Z_BYPASS_EN: bus = 0x5678, state HIGH_LEFT.
- z_low_out and z_high_out both high -> bus_drive = 0, bus_out = 0, conflict = 1 next cycle, state unchanged.
- Assert clr low mid-cycle while FULL -> outputs reset asynchronously before the next clk edge.
